// File: rtl/imem_loader.sv
// Program loader: assembles little-endian words from the debug UART byte
// stream and writes them into instruction memory until HALT, overflow or timeout.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  write_en,
  output logic [31:0]           data,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [6:0]            word_count
);

  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [6:0]  LAST_WORD = 7'((1 << (ADDR_WIDTH - 2)) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR} state_t;

  state_t           state;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_lo;
  logic [CNT_W-1:0] idle_cnt;
  logic [31:0]      full_word_c;

  // The completing byte lands directly in the top lane of the written word.
  assign full_word_c = {rx_data, asm_lo};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      byte_idx   <= 2'd0;
      asm_lo     <= 24'd0;
      idle_cnt   <= '0;
      write_en   <= 1'b0;
      data       <= 32'd0;
      addr_wr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 7'd0;
    end else begin
      write_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 7'd0;
            byte_idx   <= 2'd0;
            idle_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (byte_idx == 2'd3) begin
              data       <= full_word_c;
              addr_wr    <= ADDR_WIDTH'({word_count, 2'b00});
              write_en   <= 1'b1;
              word_count <= word_count + 7'd1;
              byte_idx   <= 2'd0;
              if (full_word_c == HALT_WORD) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (word_count == LAST_WORD) begin
                state <= ST_ERROR;
                busy  <= 1'b0;
                error <= 1'b1;
              end
            end else begin
              case (byte_idx)
                2'd0:    asm_lo[7:0]   <= rx_data;
                2'd1:    asm_lo[15:8]  <= rx_data;
                default: asm_lo[23:16] <= rx_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end else if (byte_idx != 2'd0) begin
            // Inter-byte timeout: partial word is dropped without a write.
            if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              state    <= ST_ERROR;
              busy     <= 1'b0;
              error    <= 1'b1;
              byte_idx <= 2'd0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and popped by a negedge monitor whenever write_en is seen.
module tb_imem_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [6:0]  wc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        write_en;
  logic [31:0] data;
  logic [7:0]  addr_wr;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  bit gap_chk = 1'b0;
  wr_t exp_q[$];

  imem_loader #(.ADDR_WIDTH(8), .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .write_en(write_en), .data(data), .addr_wr(addr_wr), .busy(busy), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d, input logic [6:0] wc);
    wr_t w;
    w.addr = a; w.data = d; w.wc = wc;
    exp_q.push_back(w);
  endtask

  // One clock: present rx_valid/rx_data for the next edge, return #1 after it.
  task automatic drive(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    drive(1'b0, 8'h00);
  endtask

  // Monitor: every observed write must match the head of the queue.
  always @(negedge clk) begin
    if (write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", addr_wr, data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(addr_wr), 32'(w.addr));
        check("wr_data", data, w.data);
        check("wr_count", 32'(word_count), 32'(w.wc));
      end
      if (gap_chk && last_wr_cyc >= 0) check("wr_spacing", 32'(cyc - last_wr_cyc), 32'd4);
      last_wr_cyc = cyc;
    end
  end

  logic [7:0] t1_bytes [12] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] t2_bytes [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    #1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    reset = 1'b1;
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_addr", 32'(addr_wr), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);

    // Bytes in IDLE are ignored.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hFF);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_wc", 32'(word_count), 32'd0);

    // Three words with one-cycle gaps, plus a start pulse mid-load.
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    push(8'h00, 32'h0000_0013, 7'd1);
    push(8'h04, 32'h0010_0093, 7'd2);
    push(8'h08, 32'hFFFF_FFFF, 7'd3);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, t1_bytes[i]);
      if (i == 11) begin
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_wc", 32'(word_count), 32'd3);
        check("t1_write_en", 32'(write_en), 32'd1);
      end else begin
        if (i == 5) start = 1'b1;
        drive(1'b0, 8'h00);
      end
    end
    drive(1'b0, 8'h00);

    // Bytes in DONE are ignored.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h42);
    check("done_hold", 32'(done), 32'd1);
    check("done_wc", 32'(word_count), 32'd3);

    // Restart from DONE, 12 bytes back-to-back.
    pulse_start();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_wc", 32'(word_count), 32'd0);
    push(8'h00, 32'h4433_2211, 7'd1);
    push(8'h04, 32'hDEAD_BEEF, 7'd2);
    push(8'h08, 32'hFFFF_FFFF, 7'd3);
    last_wr_cyc = -1;
    gap_chk = 1'b1;
    for (int i = 0; i < 12; i++) drive(1'b1, t2_bytes[i]);
    check("t2_done", 32'(done), 32'd1);
    drive(1'b0, 8'h00);
    gap_chk = 1'b0;

    // 64 non-HALT words: overflow after the write to 0xFC.
    pulse_start();
    for (int w = 0; w < 64; w++) begin
      push(8'(w * 4), {8'(w), 8'h00, 8'hA5, 8'h5A}, 7'(w + 1));
      drive(1'b1, 8'h5A);
      drive(1'b1, 8'hA5);
      drive(1'b1, 8'h00);
      drive(1'b1, 8'(w));
    end
    check("t3_error", 32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_wc", 32'(word_count), 32'd64);
    check("t3_busy", 32'(busy), 32'd0);
    drive(1'b0, 8'h00);

    // Byte arriving exactly at timeout expiry wins.
    pulse_start();
    check("t4_error_clr", 32'(error), 32'd0);
    drive(1'b1, 8'h01);
    for (int i = 0; i < 9; i++) drive(1'b0, 8'h00);
    drive(1'b1, 8'h02);
    check("t4_race_error", 32'(error), 32'd0);
    push(8'h00, 32'h0403_0201, 7'd1);
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h04);
    drive(1'b0, 8'h00);

    // Two bytes then idle: error 10 edges after the 2nd byte's edge.
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'hBB);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 8'h00);
      if (k == 9) check("t4_error_early", 32'(error), 32'd0);
      if (k == 10) check("t4_error", 32'(error), 32'd1);
    end
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_wc", 32'(word_count), 32'd1);

    // Reset after 6 bytes aborts the load.
    pulse_start();
    push(8'h00, 32'h4433_2211, 7'd1);
    for (int i = 0; i < 6; i++) drive(1'b1, t2_bytes[i]);
    reset = 1'b0;
    drive(1'b0, 8'h00);
    check("t5_write_en", 32'(write_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_error", 32'(error), 32'd0);
    check("t5_data", data, 32'd0);
    check("t5_addr", 32'(addr_wr), 32'd0);
    check("t5_wc", 32'(word_count), 32'd0);
    // Start during reset is ignored.
    start = 1'b1;
    drive(1'b0, 8'h00);
    check("t5_start_in_rst", 32'(busy), 32'd0);
    reset = 1'b1;
    pulse_start();
    push(8'h00, 32'hFFFF_FFFF, 7'd1);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hFF);
    check("t5_done", 32'(done), 32'd1);
    check("t5_wc_end", 32'(word_count), 32'd1);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the IF stage. It takes the byte stream from the debug UART receiver and assembles little-endian 32-bit words. It drives the instruction memory write port (`write_en`, `data`, `addr_wr`) from byte address 0 upward. It stops on the HALT word, on memory overflow or on an inter-byte timeout, and holds the pipeline in reset through `busy` while loading.

## Interface
- `ADDR_WIDTH`, 8, byte-address width of instruction memory (256 bytes, 64 words).
- `HALT_WORD`, 32'hFFFF_FFFF, end-of-program marker; it is written to memory like any other word.
- `TIMEOUT_CYCLES`, 100000, max idle cycles between bytes of one word; minimum 2.
- `clk` in 1 — single clock; every register updates on its rising edge.
- `reset` in 1 — synchronous, active-low; sampled on the rising edge of `clk`.
- `start` in 1 — one-cycle request to begin a load.
- `rx_data` in 8 — received byte.
- `rx_valid` in 1 — one-cycle strobe; `rx_data` is valid this cycle. There is no backpressure.
- `write_en` out 1 — instruction memory write strobe (one cycle per word).
- `data` out 32 — word to write; first received byte is in [7:0].
- `addr_wr` out ADDR_WIDTH — byte address of the word; always a multiple of 4.
- `busy` out 1 — high while in LOAD.
- `done` out 1 — sticky; set when the load ends with HALT.
- `error` out 1 — sticky; set on overflow or timeout.
- `word_count` out 7 — number of words written in the current load, 0..64.

## Operation
- States:
  - IDLE:
    - `start` → LOAD.
    - `rx_valid` is ignored.
  - LOAD:
    - Each `rx_valid` byte goes into byte lane `byte_idx` (2-bit, starting at 0) of the assembly register, and `byte_idx` increments.
    - When the byte that completes the word is accepted:
      - on the next edge, register `data` ← the assembled word, `addr_wr` ← {`word_count`, 2'b00}, and `write_en` ← 1 for exactly one cycle;
      - `word_count` increments on that same edge;
      - `byte_idx` wraps to 0.
    - Byte acceptance continues uninterrupted while a write is being issued. Back-to-back `rx_valid` every cycle is supported with no loss.
    - Assembled word == HALT_WORD → the word is written, then the state goes to DONE.
    - Otherwise, if `word_count` becomes 64 → ERROR (overflow). The 64th word, at address 0xFC, is still written.
    - Timeout: an idle counter runs while `byte_idx != 0` and `rx_valid` is low, and clears whenever a byte arrives.
      - Reaching TIMEOUT_CYCLES → ERROR.
      - The partial word is discarded and no write is issued.
    - `start` in LOAD is ignored.
  - DONE / ERROR:
    - `done` or `error` is held high; `rx_valid` is ignored.
    - `start` clears `done`, `error`, `word_count`, `byte_idx` and the idle counter, then goes to LOAD, restarting at address 0.
- `busy` = (state == LOAD).
- Address arithmetic: `addr_wr` = `word_count` × 4, truncated to ADDR_WIDTH. Overflow detection guarantees it never wraps past 0xFC.
- `addr_wr` and `data` hold their last written values between writes. Memory content is only trusted on `write_en`.

## Timing
- Reset (`reset` low at an edge):
  - state ← IDLE.
  - `write_en`, `busy`, `done`, `error` ← 0.
  - `data` ← 0, `addr_wr` ← 0, `word_count` ← 0.
  - `byte_idx`, the assembly register and the idle counter are cleared.
- Reset mid-load aborts immediately. A pending write is cancelled and the partial word is lost.
- `start` at edge N → `busy` = 1 from cycle N+1. A byte with `rx_valid` in cycle N is not accepted; the first accepted byte can arrive in cycle N+1.
- Word-completing byte accepted at edge N:
  - `write_en` = 1 during cycle N+1, with `data`, `addr_wr` and the incremented `word_count` valid in the same cycle.
  - If the word was HALT or the 64th word: `done` or `error` = 1 and `busy` = 0 also from cycle N+1.
- Timeout: the last byte at edge N → `error` = 1 at cycle N + TIMEOUT_CYCLES + 1.
- Simultaneous `rx_valid` and timeout expiry in the same cycle: the byte wins and the counter clears.
- Simultaneous `start` and `reset` low: reset wins.

## Test plan
- Load three words (bytes 0x13,0x00,0x00,0x00 / 0x93,0x00,0x10,0x00 / FF,FF,FF,FF) with one-cycle gaps:
  - three `write_en` pulses at addresses 0x00, 0x04, 0x08;
  - data 0x00000013, 0x00100093, 0xFFFFFFFF;
  - `done` = 1, `word_count` = 3, `busy` = 0 the cycle after the third write.
- 12 bytes back-to-back (`rx_valid` held high) ending in HALT:
  - writes occur 4 cycles apart with no dropped byte;
  - the word at 0x04 is exact.
- 64 non-HALT words: the 64th write goes to 0xFC, then `error` = 1, `done` = 0, and `word_count` = 64.
- Send 2 bytes, then idle (TIMEOUT_CYCLES = 10):
  - `error` rises exactly 11 cycles after the 2nd byte;
  - no `write_en`.
- Assert `reset` low after 6 bytes of a load:
  - all outputs return to 0 next cycle;
  - a new `start` followed by a 4-byte HALT writes 0xFFFFFFFF at address 0x00.
- While in IDLE or DONE, pulse `rx_valid` and pulse `start` while in LOAD:
  - no `write_en` in IDLE or DONE;
  - the LOAD sequence continues unaffected;
  - `start` from DONE restarts at address 0 with `done` cleared.
